pipeline_hazard_ctrl: RTL and testbench

//  Parametrised hazard/stall controller for the 5-stage RV pipeline; replaces the combinational hazard unit.

---
 rtl/pipeline_hazard_ctrl_if.sv | 49 ++++
 rtl/pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and the hazard controller.
// The master drives register addresses and requests; the slave returns stall, flush and forward controls.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int EXT_N = 2,
    parameter int CNT_W = 16
);
    logic             RegWriteM;
    logic             RegWriteW;
    logic [REG_W-1:0] RdM;
    logic [REG_W-1:0] RdW;
    logic [REG_W-1:0] RdE;
    logic [REG_W-1:0] Rs1E;
    logic [REG_W-1:0] Rs2E;
    logic [REG_W-1:0] Rs1D;
    logic [REG_W-1:0] Rs2D;
    logic             ResultSrcE0;
    logic             PCSrcE;
    logic             MulStartE;
    logic [EXT_N-1:0] ExtStall;

    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             StallW;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             MulDoneE;
    logic [CNT_W-1:0] StallCycles;
    logic [CNT_W-1:0] FlushCount;

    modport master (
        output RegWriteM, RegWriteW, RdM, RdW, RdE, Rs1E, Rs2E, Rs1D, Rs2D,
               ResultSrcE0, PCSrcE, MulStartE, ExtStall,
        input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM,
               ForwardAE, ForwardBE, MulDoneE, StallCycles, FlushCount
    );

    modport slave (
        input  RegWriteM, RegWriteW, RdM, RdW, RdE, Rs1E, Rs2E, Rs1D, Rs2D,
               ResultSrcE0, PCSrcE, MulStartE, ExtStall,
        output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM,
               ForwardAE, ForwardBE, MulDoneE, StallCycles, FlushCount
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV pipeline: forwarding, load-use and branch hazards,
// external stall sources with per-source freeze scope, multi-cycle multiply sequencing and statistics.
module pipeline_hazard_ctrl #(
    parameter int             REG_W       = 5,
    parameter int             MUL_LATENCY = 4,
    parameter int             EXT_N       = 2,
    parameter logic [EXT_N-1:0] FREEZE_MASK = 2'b10,
    parameter int             CNT_W       = 16
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    logic       frz;
    logic       front;
    logic       lw_stall;
    logic       branch_wait;
    logic       mul_stall;
    logic       mul_done;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall_f, stall_d, stall_e, stall_m, stall_w;
    logic       flush_d, flush_e, flush_m;

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (hz.RegWriteM && (hz.RdM != '0) && (hz.RdM == rs)) begin
            sel = 2'b10;
        end else if (hz.RegWriteW && (hz.RdW != '0) && (hz.RdW == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a    = fwd_sel(hz.Rs1E);
        fwd_b    = fwd_sel(hz.Rs2E);
        frz      = |(hz.ExtStall & FREEZE_MASK);
        front    = |(hz.ExtStall & ~FREEZE_MASK);
        lw_stall = hz.ResultSrcE0 && (hz.RdE != '0) &&
                   ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    end

    generate
        if (MUL_LATENCY > 1) begin : g_mul
            // cnt_q holds the number of BUSY cycles still to come after the current one,
            // so the start cycle plus all BUSY cycles add up to MUL_LATENCY-1 stall cycles.
            localparam int CW = $clog2(MUL_LATENCY);
            localparam logic [CW-1:0] LOAD = CW'((MUL_LATENCY > 2) ? (MUL_LATENCY - 3) : 0);

            mul_state_e    state_q;
            logic [CW-1:0] cnt_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else if (!frz) begin
                    case (state_q)
                        IDLE: begin
                            if (hz.MulStartE) begin
                                if (MUL_LATENCY == 2) begin
                                    state_q <= DONE;
                                end else begin
                                    state_q <= BUSY;
                                    cnt_q   <= LOAD;
                                end
                            end
                        end
                        BUSY: begin
                            if (cnt_q == '0) begin
                                state_q <= DONE;
                            end else begin
                                cnt_q <= cnt_q - 1'b1;
                            end
                        end
                        DONE:    state_q <= IDLE;
                        default: state_q <= IDLE;
                    endcase
                end
            end

            assign mul_stall = ((state_q == IDLE) && hz.MulStartE) || (state_q == BUSY);
            assign mul_done  = (state_q == DONE);
        end else begin : g_nomul
            assign mul_stall = 1'b0;
            assign mul_done  = hz.MulStartE;
        end
    endgenerate

    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        stall_w     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_m     = 1'b0;
        branch_wait = 1'b0;
        if (frz) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            stall_w = 1'b1;
        end else begin
            // A taken branch blocked by a front-end stall parks in E until the stall clears.
            branch_wait = hz.PCSrcE && front;
            stall_e     = mul_stall || branch_wait;
            stall_f     = mul_stall || front || lw_stall;
            stall_d     = stall_f;
            flush_m     = mul_stall || branch_wait;
            flush_e     = (front && !stall_e) || lw_stall || (hz.PCSrcE && !front);
            flush_d     = hz.PCSrcE && !front;
        end
    end

    assign hz.StallF    = rst & stall_f;
    assign hz.StallD    = rst & stall_d;
    assign hz.StallE    = rst & stall_e;
    assign hz.StallM    = rst & stall_m;
    assign hz.StallW    = rst & stall_w;
    assign hz.FlushD    = rst & flush_d;
    assign hz.FlushE    = rst & flush_e;
    assign hz.FlushM    = rst & flush_m;
    assign hz.MulDoneE  = rst & mul_done;
    assign hz.ForwardAE = rst ? fwd_a : 2'b00;
    assign hz.ForwardBE = rst ? fwd_b : 2'b00;

    logic [1:0]       stat_ev;
    logic [CNT_W-1:0] stat_q [2];

    assign stat_ev = {hz.FlushD, hz.StallF};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    stat_q[gi] <= '0;
                end else if (stat_ev[gi] && (stat_q[gi] != {CNT_W{1'b1}})) begin
                    stat_q[gi] <= stat_q[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign hz.StallCycles = stat_q[0];
    assign hz.FlushCount  = stat_q[1];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios then random traffic, checked against
// a cycle-level behavioural model; a second instance with 4-bit counters checks saturation.
module tb_pipeline_hazard_ctrl;

    localparam int          ML    = 4;
    localparam logic [1:0]  FMASK = 2'b10;

    typedef struct packed {
        logic       rwm, rww;
        logic [4:0] rdm, rdw, rde, rs1e, rs2e, rs1d, rs2d;
        logic       ld, pcs, mul;
        logic [1:0] ext;
    } stim_t;

    typedef struct {
        bit  sf, sd, se, sm, sw, fd, fe, fm, md;
        int  fa, fb, scyc, fcnt, sat;
        bit  verbose;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb_q[$];

    int  m_rem, m_stall, m_flush;
    bit  m_done;
    bit  mul_active;

    pipeline_hazard_ctrl_if #(.REG_W(5), .EXT_N(2), .CNT_W(16)) if0 ();
    pipeline_hazard_ctrl_if #(.REG_W(5), .EXT_N(2), .CNT_W(4))  if1 ();

    pipeline_hazard_ctrl #(.REG_W(5), .MUL_LATENCY(ML), .EXT_N(2), .FREEZE_MASK(FMASK), .CNT_W(16))
        dut (.clk(clk), .rst(rst), .hz(if0));
    pipeline_hazard_ctrl #(.REG_W(5), .MUL_LATENCY(ML), .EXT_N(2), .FREEZE_MASK(FMASK), .CNT_W(4))
        dut_sat (.clk(clk), .rst(rst), .hz(if1));

    assign if1.RegWriteM   = if0.RegWriteM;
    assign if1.RegWriteW   = if0.RegWriteW;
    assign if1.RdM         = if0.RdM;
    assign if1.RdW         = if0.RdW;
    assign if1.RdE         = if0.RdE;
    assign if1.Rs1E        = if0.Rs1E;
    assign if1.Rs2E        = if0.Rs2E;
    assign if1.Rs1D        = if0.Rs1D;
    assign if1.Rs2D        = if0.Rs2D;
    assign if1.ResultSrcE0 = if0.ResultSrcE0;
    assign if1.PCSrcE      = if0.PCSrcE;
    assign if1.MulStartE   = if0.MulStartE;
    assign if1.ExtStall    = if0.ExtStall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fwd(input stim_t s, input logic [4:0] rs);
        if (s.rwm && s.rdm != 0 && s.rdm == rs) return 2;
        if (s.rww && s.rdw != 0 && s.rdw == rs) return 1;
        return 0;
    endfunction

    // Reference: the multiply is tracked as "stall cycles still owed" plus a pending done pulse.
    task automatic model_step(input stim_t s, output exp_t e);
        bit frz, front, lw, mst, bw;
        int rem;
        e = '{default: 0};
        frz   = |(s.ext & FMASK);
        front = |(s.ext & ~FMASK);
        lw    = s.ld && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
        e.fa   = fwd(s, s.rs1e);
        e.fb   = fwd(s, s.rs2e);
        e.scyc = m_stall;
        e.fcnt = m_flush;
        e.sat  = (m_stall > 15) ? 15 : m_stall;
        mst = 0;
        if (m_done) begin
            e.md = 1;
            if (!frz) m_done = 0;
        end else if (m_rem > 0 || s.mul) begin
            rem = (m_rem > 0) ? m_rem : ML - 1;
            mst = 1;
            if (!frz) begin
                m_rem = rem - 1;
                if (m_rem == 0) m_done = 1;
            end
        end
        if (frz) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.sw = 1;
        end else begin
            bw   = s.pcs && front;
            e.se = mst || bw;
            e.sf = mst || front || lw;
            e.sd = e.sf;
            e.fm = mst || bw;
            e.fe = (front && !e.se) || lw || (s.pcs && !front);
            e.fd = s.pcs && !front;
        end
        if (e.sf && m_stall < 65535) m_stall++;
        if (e.fd && m_flush < 65535) m_flush++;
    endtask

    task automatic drive(input stim_t s);
        if0.RegWriteM   = s.rwm;
        if0.RegWriteW   = s.rww;
        if0.RdM         = s.rdm;
        if0.RdW         = s.rdw;
        if0.RdE         = s.rde;
        if0.Rs1E        = s.rs1e;
        if0.Rs2E        = s.rs2e;
        if0.Rs1D        = s.rs1d;
        if0.Rs2D        = s.rs2d;
        if0.ResultSrcE0 = s.ld;
        if0.PCSrcE      = s.pcs;
        if0.MulStartE   = s.mul;
        if0.ExtStall    = s.ext;
    endtask

    task automatic apply(input stim_t s, input bit verbose);
        exp_t e;
        @(posedge clk);
        #1;
        drive(s);
        model_step(s, e);
        e.verbose = verbose;
        sb_q.push_back(e);
        mul_active = s.mul && !e.md;
    endtask

    function automatic stim_t zero_stim();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rwm  = 1'($urandom_range(0, 1));
        s.rww  = 1'($urandom_range(0, 1));
        s.rdm  = 5'($urandom_range(0, 7));
        s.rdw  = 5'($urandom_range(0, 7));
        s.rde  = 5'($urandom_range(0, 7));
        s.rs1e = 5'($urandom_range(0, 7));
        s.rs2e = 5'($urandom_range(0, 7));
        s.rs1d = 5'($urandom_range(0, 7));
        s.rs2d = 5'($urandom_range(0, 7));
        s.ld   = ($urandom_range(0, 3) == 0);
        s.pcs  = ($urandom_range(0, 4) == 0);
        s.mul  = mul_active ? 1'b1 : ($urandom_range(0, 7) == 0);
        s.ext  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        if (s.mul) begin
            s.ld  = 1'b0;
            s.pcs = 1'b0;
        end
        return s;
    endfunction

    // Monitor: every cycle with a pending expectation, compare all controls mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.verbose)
                    $display("txn t=%0t stall=%b%b%b%b%b flush=%b%b%b fwd=%0d/%0d muldone=%b stalls=%0d flushes=%0d",
                             $time, if0.StallF, if0.StallD, if0.StallE, if0.StallM, if0.StallW,
                             if0.FlushD, if0.FlushE, if0.FlushM, if0.ForwardAE, if0.ForwardBE,
                             if0.MulDoneE, if0.StallCycles, if0.FlushCount);
                chk("StallF", int'(if0.StallF), int'(e.sf));
                chk("StallD", int'(if0.StallD), int'(e.sd));
                chk("StallE", int'(if0.StallE), int'(e.se));
                chk("StallM", int'(if0.StallM), int'(e.sm));
                chk("StallW", int'(if0.StallW), int'(e.sw));
                chk("FlushD", int'(if0.FlushD), int'(e.fd));
                chk("FlushE", int'(if0.FlushE), int'(e.fe));
                chk("FlushM", int'(if0.FlushM), int'(e.fm));
                chk("ForwardAE", int'(if0.ForwardAE), e.fa);
                chk("ForwardBE", int'(if0.ForwardBE), e.fb);
                chk("MulDoneE", int'(if0.MulDoneE), int'(e.md));
                chk("StallCycles", int'(if0.StallCycles), e.scyc);
                chk("FlushCount", int'(if0.FlushCount), e.fcnt);
                chk("StallCycles_sat4", int'(if1.StallCycles), e.sat);
            end
        end
    end

    task automatic model_reset();
        m_rem      = 0;
        m_done     = 0;
        m_stall    = 0;
        m_flush    = 0;
        mul_active = 0;
    endtask

    initial begin
        stim_t s;
        int    wait_cyc;
        total = 0;
        bad   = 0;
        model_reset();
        drive(zero_stim());
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_StallF", int'(if0.StallF), 0);
        chk("reset_StallCycles", int'(if0.StallCycles), 0);
        @(negedge clk);
        rst = 1'b1;

        // Forwarding: M beats W, W when M is x0, register x0 never forwards.
        s = zero_stim();
        s.rs1e = 5; s.rdm = 5; s.rwm = 1; s.rdw = 5; s.rww = 1; s.rs2e = 5;
        apply(s, 1);
        s.rdm = 0;
        apply(s, 1);
        s.rs2e = 0;
        apply(s, 1);

        // Multiply alone, then multiply interrupted by a 2-cycle freeze.
        s = zero_stim();
        s.mul = 1;
        repeat (4) apply(s, 1);
        apply(zero_stim(), 1);
        apply(s, 1);
        s.ext = 2'b10;
        repeat (2) apply(s, 1);
        s.ext = 2'b00;
        repeat (3) apply(s, 1);
        apply(zero_stim(), 1);

        // Taken branch parked behind an icache stall, released when the stall drops.
        s = zero_stim();
        s.pcs = 1; s.ext = 2'b01;
        repeat (3) apply(s, 1);
        s.ext = 2'b00;
        apply(s, 1);
        apply(zero_stim(), 1);

        // Load-use hazard, then the same pattern with a load to x0.
        s = zero_stim();
        s.ld = 1; s.rde = 7; s.rs2d = 7;
        apply(s, 1);
        s.rde = 0; s.rs2d = 0;
        apply(s, 1);

        // Asynchronous reset in the middle of a multiply.
        s = zero_stim();
        s.mul = 1;
        repeat (2) apply(s, 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_StallF", int'(if0.StallF), 0);
        chk("async_StallE", int'(if0.StallE), 0);
        chk("async_FlushM", int'(if0.FlushM), 0);
        chk("async_MulDoneE", int'(if0.MulDoneE), 0);
        chk("async_StallCycles", int'(if0.StallCycles), 0);
        sb_q.delete();
        drive(zero_stim());
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        apply(zero_stim(), 1);

        // Twenty front-end stall cycles push the 4-bit counter into saturation.
        s = zero_stim();
        s.ext = 2'b01;
        repeat (20) apply(s, 1);
        apply(zero_stim(), 1);

        for (int i = 0; i < 2000; i++) begin
            apply(rand_stim(), 0);
        end
        apply(zero_stim(), 0);

        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
